// File: rtl/aer_pkg.sv
// aer_pkg: shared FSM encoding, width helpers and bit-scan functions for the AER encoder
package aer_pkg;
  localparam int max_tile = 64;
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} aer_state_t;
  function automatic int sel_width(int n);
    return $clog2(n);
  endfunction
  function automatic int addr_width(int id_w, int n);
    return id_w + $clog2(n);
  endfunction
  function automatic int lowest_set(logic [max_tile-1:0] v);
    int r;
    r = 0;
    for (int i = max_tile - 1; i >= 0; i--)
      if (v[i]) r = i;
    return r;
  endfunction
  function automatic logic is_onehot(logic [max_tile-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/spike_vec_fifo.sv
// spike_vec_fifo: small registered vector FIFO with occupancy count, sync active-low reset
module spike_vec_fifo #(
  parameter int width = 4,
  parameter int depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [width-1:0]       din,
  input  logic                   pop,
  output logic [width-1:0]       dout,
  output logic [$clog2(depth):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = count == (aw+1)'(depth);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (aw+1)'(do_push) - (aw+1)'(do_pop);
    end
  end
endmodule

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: buffers tile spike vectors and serializes set bits into {tile_id, index} AER words
module spike_aer_encoder
  import aer_pkg::*;
#(
  parameter int size_tile    = 4,
  parameter int size_tile_id = 4,
  parameter int tile_id      = 0,
  parameter int fifo_depth   = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          in_spikeValid,
  input  logic [size_tile-1:0]                          in_spike,
  input  logic                                          out_ready,
  output logic                                          out_valid,
  output logic [addr_width(size_tile_id, size_tile)-1:0] out_addr,
  output logic                                          out_last,
  output logic                                          overflow,
  output logic                                          busy
);
  localparam int size_select = sel_width(size_tile);
  aer_state_t state, state_n;
  logic [size_tile-1:0] w, w_src, dout;
  logic [$clog2(fifo_depth):0] fifo_count;
  logic full, empty, cap, pop, upd;
  assign cap = in_spikeValid && (in_spike != '0);
  spike_vec_fifo #(.width(size_tile), .depth(fifo_depth)) u_fifo (
    .clk(clk), .reset(reset), .push(cap && !full), .din(in_spike), .pop(pop),
    .dout(dout), .count(fifo_count), .full(full), .empty(empty)
  );
  always_comb begin
    pop     = (state == IDLE) && !empty;
    upd     = pop || ((state == EMIT) && out_ready);
    w_src   = pop ? dout : w & ~(size_tile'(1) << out_addr[size_select-1:0]);
    state_n = pop ? EMIT : ((state == EMIT) && out_ready && out_last) ? IDLE : state;
  end
  // out_addr/out_last are recomputed from the value w takes at this edge, so they stay registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      w        <= '0;
      out_addr <= '0;
      out_last <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (upd) begin
        w        <= w_src;
        out_addr <= {size_tile_id'(tile_id), size_select'(lowest_set(max_tile'(w_src)))};
        out_last <= is_onehot(max_tile'(w_src));
      end
      if (cap && full) overflow <= 1'b1;
    end
  end
  assign out_valid = state == EMIT;
  assign busy      = (fifo_count != '0) || (state != IDLE);
endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb_spike_aer_encoder: queue-based reference model plus table-driven and hand-written sequences
module tb_spike_aer_encoder;
  localparam int N = 4, IDW = 4, TID = 10, D = 4;
  logic clk = 1'b0, reset = 1'b0, in_spikeValid = 1'b0, out_ready = 1'b0;
  logic [N-1:0] in_spike = '0;
  logic out_valid, out_last, overflow, busy;
  logic [5:0] out_addr;
  int total = 0, bad = 0;
  bit chk_en = 0;
  int q[$];
  int cur[$];
  bit m_ovf = 0;

  spike_aer_encoder #(.size_tile(N), .size_tile_id(IDW), .tile_id(TID), .fifo_depth(D)) dut (
    .clk(clk), .reset(reset), .in_spikeValid(in_spikeValid), .in_spike(in_spike),
    .out_ready(out_ready), .out_valid(out_valid), .out_addr(out_addr), .out_last(out_last),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // reference: q holds buffered vectors, cur the indices still to be sent from the active vector
  always @(posedge clk) begin
    int pre, v;
    if (!reset) begin
      q.delete();
      cur.delete();
      m_ovf = 0;
    end else begin
      pre = q.size();
      if (cur.size() > 0) begin
        if (out_ready) void'(cur.pop_front());
      end else if (q.size() > 0) begin
        v = q.pop_front();
        for (int i = 0; i < N; i++) if (v[i]) cur.push_back(i);
      end
      if (in_spikeValid && in_spike != 0) begin
        if (pre < D) q.push_back(int'(in_spike));
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("m_valid", 32'(out_valid), 32'(cur.size() > 0));
    if (cur.size() > 0) begin
      chk("m_addr", 32'(out_addr), 32'(TID * 4 + cur[0]));
      chk("m_last", 32'(out_last), 32'(cur.size() == 1));
    end
    chk("m_busy", 32'(busy), 32'(q.size() > 0 || cur.size() > 0));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    in_spikeValid = 1'b1;
    in_spike = v;
    tick();
    in_spikeValid = 1'b0;
    in_spike = '0;
  endtask

  task automatic settle();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("settle_idle", 32'(busy), 0);
  endtask

  typedef struct {
    logic [N-1:0] v;
    int n;
    int first;
    int lastidx;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int cnt, first, lastidx;
    tbl[0] = '{4'b1010, 2, 1, 3};
    tbl[1] = '{4'b0001, 1, 0, 0};
    tbl[2] = '{4'b1000, 1, 3, 3};
    tbl[3] = '{4'b1111, 4, 0, 3};
    tbl[4] = '{4'b0110, 2, 1, 2};
    tbl[5] = '{4'b0101, 2, 0, 2};
    tbl[6] = '{4'b0000, 0, 0, 0};
    tick();
    chk_en = 1;
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_addr", 32'(out_addr), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1'b1;
    tick();

    // single vector latency
    out_ready = 1'b1;
    pulse(4'b1010);
    chk("sv_c1_valid", 32'(out_valid), 0);
    tick();
    chk("sv_c2_valid", 32'(out_valid), 1);
    chk("sv_c2_addr", 32'(out_addr), TID * 4 + 1);
    chk("sv_c2_last", 32'(out_last), 0);
    tick();
    chk("sv_c3_addr", 32'(out_addr), TID * 4 + 3);
    chk("sv_c3_last", 32'(out_last), 1);
    tick();
    chk("sv_c4_valid", 32'(out_valid), 0);
    chk("sv_c4_busy", 32'(busy), 0);

    // table-driven vectors
    foreach (tbl[k]) begin
      out_ready = 1'b1;
      cnt = 0; first = -1; lastidx = -1;
      pulse(tbl[k].v);
      for (int c = 0; c < 12; c++) begin
        if (out_valid && out_ready) begin
          cnt++;
          if (cnt == 1) first = int'(out_addr[1:0]);
          if (out_last) lastidx = int'(out_addr[1:0]);
        end
        tick();
      end
      chk($sformatf("tbl%0d_cnt", k), 32'(cnt), 32'(tbl[k].n));
      if (tbl[k].n > 0) begin
        chk($sformatf("tbl%0d_first", k), 32'(first), 32'(tbl[k].first));
        chk($sformatf("tbl%0d_lastidx", k), 32'(lastidx), 32'(tbl[k].lastidx));
      end
      chk($sformatf("tbl%0d_ovf", k), 32'(overflow), 0);
    end

    // back-pressure hold
    out_ready = 1'b0;
    pulse(4'b0110);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_addr", 32'(out_addr), TID * 4 + 1);
      chk("bp_hold_last", 32'(out_last), 0);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_w0", 32'(out_addr), TID * 4 + 1);
    tick();
    chk("bp_w1", 32'(out_addr), TID * 4 + 2);
    chk("bp_w1_last", 32'(out_last), 1);
    tick();
    chk("bp_done", 32'(out_valid), 0);

    // zero vector
    pulse(4'b0000);
    tick(); tick();
    chk("zero_valid", 32'(out_valid), 0);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_ovf", 32'(overflow), 0);

    // overflow: six back-to-back nonzero pulses under back-pressure
    out_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      in_spikeValid = 1'b1;
      in_spike = N'(1 << (p % 4));
      tick();
    end
    in_spikeValid = 1'b0;
    in_spike = '0;
    chk("ovf_set", 32'(overflow), 1);
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_ready) cnt++;
      tick();
    end
    chk("ovf_words", 32'(cnt), 5);
    chk("ovf_sticky", 32'(overflow), 1);

    // reset mid-EMIT
    pulse(4'b1111);
    tick();
    chk("rm_emit", 32'(out_valid), 1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rm_valid", 32'(out_valid), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_ovf", 32'(overflow), 0);
    pulse(4'b1000);
    tick();
    chk("rm_new_addr", 32'(out_addr), TID * 4 + 3);
    chk("rm_new_last", 32'(out_last), 1);
    tick();
    chk("rm_new_done", 32'(out_valid), 0);

    // simultaneous push with IDLE pop keeps the count
    pulse(4'b0001);
    pulse(4'b0010);
    chk("pp_count", 32'(dut.u_fifo.count), 1);
    chk("pp_addr_hi", 32'(out_addr[5:2]), TID);
    settle();

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(9) < 7);
      in_spikeValid = ($urandom_range(9) < 3);
      in_spike = N'($urandom_range(15));
      reset = !($urandom_range(199) == 0);
      tick();
    end
    in_spikeValid = 1'b0;
    reset = 1'b1;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
- Sits directly downstream of the neuron tile.
- Captures each tile spike vector on the one-cycle `in_spikeValid` pulse and buffers it in a small vector FIFO.
- Serializes the set bits, lowest index first, into address-event (AER) words `{tile_id, neuron_index}`.
- Delivers words on a valid/ready stream to the network-on-chip / spike router.

Parameters:
- size_tile, 4, number of neurons per tile (width of spike vector); must be ≥ 2.
- size_tile_id, 4, width of the tile identifier field.
- tile_id, 0, constant identifier of this tile, placed in address MSBs.
- fifo_depth, 4, number of spike vectors buffered; power of 2, ≥ 2.
- Derived, not overridable: size_select = clog2(size_tile); size_addr = size_tile_id + size_select.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_spikeValid  input  1  one-cycle pulse: `in_spike` holds a completed spike vector.
- in_spike  input  size_tile  spike vector, bit i = neuron i fired.
- out_ready  input  1  downstream accepts the current word.
- out_valid  output  1  `out_addr` / `out_last` are valid.
- out_addr  output  size_addr  `{tile_id, index of lowest remaining set bit}`.
- out_last  output  1  current word is the final spike of its vector.
- overflow  output  1  sticky: a nonzero vector was dropped because the FIFO was full.
- busy  output  1  FIFO nonempty or FSM not in IDLE.

Behaviour:
- Reset (`reset == 0` at a clock edge):
  - Outputs: out_valid, out_addr, out_last, overflow and busy are all 0.
  - FIFO is emptied and the working register is cleared.
  - State goes to IDLE.
  - Applies mid-operation: words in flight are discarded and the next cycle shows out_valid = 0.
- Capture:
  - Sampled at an edge where `in_spikeValid == 1`.
  - If `in_spike == 0`, the vector is ignored: no push, no overflow.
  - Else if FIFO count < fifo_depth, `in_spike` is pushed.
  - Else the vector is dropped and overflow is set; it stays 1 until reset.
  - "Full" is evaluated on the pre-edge count. A same-cycle pop does not rescue the push.
- FIFO: count 0..fifo_depth; read and write pointers wrap modulo fifo_depth. A simultaneous push and pop leaves count unchanged.
- FSM states, encoded in the shared package:
  - IDLE: out_valid = 0. If count > 0, pop the head into working register w at the edge and go to EMIT; otherwise stay in IDLE.
  - EMIT: out_valid = 1.
    - out_addr = `{tile_id, p}`, where p is the lowest set-bit index of w.
    - out_last = 1 iff w has exactly one set bit.
    - On an edge with out_ready = 1: clear bit p of w. If out_last was 1, go to IDLE; otherwise stay in EMIT.
    - With out_ready = 0: out_valid, out_addr and out_last are held stable.
- Outputs are registered: out_addr and out_last update at the same edge that loads or modifies w.
- Latency: a pulse in cycle 0 is pushed at the end of cycle 0, popped at the end of cycle 1, and out_valid = 1 in cycle 2.
- Throughput:
  - One word per cycle while out_ready = 1.
  - One idle cycle (IDLE) between consecutive vectors.
  - A vector with k set bits occupies EMIT for exactly k accepted handshakes.
- w is never zero in EMIT, because zero vectors are never pushed.
- Captures continue during EMIT; the FIFO absorbs back-pressure.
- busy = (count != 0) OR (state != IDLE); busy is combinational from registers.

Decomposition:
- Package `aer_pkg`:
  - FSM state enum: IDLE = 0, EMIT = 1.
  - clog2-based width constants (size_select, size_addr).
  - Lowest-set-bit priority-encode function.
  - Exactly-one-bit (onehot) check function.
- Sub-module `spike_vec_fifo`:
  - Parameters: width, depth.
  - Ports: clk, reset, push, din, pop, dout, count, full, empty.
  - Synchronous active-low reset; registered storage.
- Top level holds the capture/drop logic, the FSM, w, and the output registers.

Test Plan:
- Single vector: pulse with `in_spike = 4'b1010`, out_ready tied 1 → cycles 2 and 3 show out_addr = `{0, 2'd1}` with out_last = 0, then out_addr = `{0, 2'd3}` with out_last = 1; cycle 4 out_valid = 0, busy = 0.
- Back-pressure: `in_spike = 4'b0110`, out_ready = 0 for 5 cycles then 1 → out_addr = `{0, 2'd1}` is held stable for 5 cycles with out_valid = 1, then indices 1 and 2 are emitted in order.
- Zero vector: pulse with `in_spike = 0` → no output, count stays 0, busy = 0, overflow = 0.
- Overflow:
  - Setup: out_ready = 0; issue 6 pulses 4'b0001, 4'b0010, … (nonzero each).
  - First vector moves to w; the next 4 fill the FIFO.
  - The 6th pulse is dropped → overflow = 1 and stays 1.
  - After out_ready = 1, exactly 5 words emerge.
- Reset mid-EMIT: `in_spike = 4'b1111`, accept 1 word, then drop reset low for 1 cycle → out_valid, busy and overflow are all 0. A new pulse 4'b1000 afterwards yields a single word, index 3 with out_last = 1.
- Simultaneous push/pop and tile_id: set tile_id = 4'hA, fifo_depth = 4; push a new vector on the same edge that IDLE pops → count unchanged. out_addr MSBs = 4'hA on every word.
